multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle processor control unit. It sequences each instruction through fetch, decode, execute, memory and write-back states. It holds a single shared memory port with a req/ready handshake and variable wait states, and enforces a bus-timeout error. It sits between the instruction register and the datapath, and drives the same datapath selects as the single-cycle unit plus the multi-cycle enables.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_control_unit.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit: state enum,
// decoded instruction classes, opcode values and datapath select codes.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_ERR
  } state_e;

  // Opcodes are reduced to a class once in DECODE so later states never look at the IR.
  typedef enum logic [3:0] {
    CL_ALU_RR,
    CL_ALU_IMM,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_JMP,
    CL_JAL,
    CL_HLT,
    CL_ILL
  } op_class_e;

  localparam int unsigned OP_ALU_RR  = 0;
  localparam int unsigned OP_ALU_IMM = 1;
  localparam int unsigned OP_LD      = 2;
  localparam int unsigned OP_ST      = 3;
  localparam int unsigned OP_BR      = 4;
  localparam int unsigned OP_JMP     = 5;
  localparam int unsigned OP_JAL     = 6;

  localparam logic [1:0] ALUIN_REG = 2'b00;
  localparam logic [1:0] ALUIN_IMM = 2'b01;
  localparam logic [1:0] ALUIN_PC  = 2'b10;

  localparam logic [2:0] ALUOP_ADD = 3'b000;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive wait cycles of the shared memory port and flags a bus
// timeout; a ready arriving in the cycle the limit is reached still completes.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(MEM_TIMEOUT + 1);
      logic [CW-1:0] count;

      // NOTE: sequential state is updated with <= so every flop samples the
      // pre-edge values of its inputs, independent of block ordering.
      always_ff @(posedge clk) begin
        if (reset || !active || ready) begin
          count <= '0;
        end else if (count != CW'(MEM_TIMEOUT)) begin
          count <= count + CW'(1);
        end
      end

      assign expired = active && !ready && (count == CW'(MEM_TIMEOUT));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle processor control: FETCH/DECODE/EXEC/MEM/WB sequencing over one
// shared memory port with req/ready handshake, bus timeout and retire counter.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                AdSel,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                ir_write,
  output logic                pc_write,
  output logic                unconditional,
  output logic [2:0]          conditional,
  output logic [2:0]          ALUop,
  output logic [1:0]          ALUinSel,
  output logic                RegWrite,
  output logic                RegSelect,
  output logic                MemtoReg,
  output logic                DataPCSel,
  output logic                halt,
  output logic                bus_err,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  state_e             state, state_nxt;
  op_class_e          cls_dec, cls_q;
  logic [FUNCT_W-1:0] funct_q;
  logic               retire;
  logic               expired;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (mem_req),
    .ready   (mem_ready),
    .expired (expired)
  );

  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cls_dec = CL_ILL;
    if (opcode == '1) begin
      cls_dec = CL_HLT;
    end else begin
      case (opcode)
        OPCODE_W'(OP_ALU_RR):  cls_dec = CL_ALU_RR;
        OPCODE_W'(OP_ALU_IMM): cls_dec = CL_ALU_IMM;
        OPCODE_W'(OP_LD):      cls_dec = CL_LD;
        OPCODE_W'(OP_ST):      cls_dec = CL_ST;
        OPCODE_W'(OP_BR):      cls_dec = CL_BR;
        OPCODE_W'(OP_JMP):     cls_dec = CL_JMP;
        OPCODE_W'(OP_JAL):     cls_dec = CL_JAL;
        default:               cls_dec = CL_ILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q   <= CL_ILL;
      funct_q <= '0;
    end else if (state == ST_DECODE) begin
      cls_q   <= cls_dec;
      funct_q <= funct;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired <= '0;
    end else if (retire) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // retire marks the completing state of each instruction; it takes effect on the exit edge.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)    state_nxt = ST_DECODE;
        else if (expired) state_nxt = ST_ERR;
      end
      ST_DECODE: begin
        if (cls_dec == CL_HLT) begin
          state_nxt = ST_HALT;
        end else if (cls_dec == CL_ILL) begin
          state_nxt = ST_FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CL_ALU_RR, CL_ALU_IMM: state_nxt = ST_WB;
          CL_LD, CL_ST:          state_nxt = ST_MEM;
          default: begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          if (cls_q == CL_LD) begin
            state_nxt = ST_WB;
          end else begin
            state_nxt = ST_FETCH;
            retire    = 1'b1;
          end
        end else if (expired) begin
          state_nxt = ST_ERR;
        end
      end
      ST_WB: begin
        state_nxt = ST_FETCH;
        retire    = 1'b1;
      end
      ST_HALT:  state_nxt = ST_HALT;
      ST_ERR:   state_nxt = ST_ERR;
      default:  state_nxt = ST_RST;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    AdSel         = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    unconditional = 1'b0;
    conditional   = 3'b000;
    ALUop         = 3'b000;
    ALUinSel      = ALUIN_REG;
    RegWrite      = 1'b0;
    RegSelect     = 1'b0;
    MemtoReg      = 1'b0;
    DataPCSel     = 1'b0;
    halt          = 1'b0;
    bus_err       = 1'b0;
    illegal       = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req  = 1'b1;
        MemRead  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      // The IR already holds the new word here, so the illegal pulse decodes it live.
      ST_DECODE: illegal = (cls_dec == CL_ILL);
      ST_EXEC: begin
        case (cls_q)
          CL_ALU_RR:  ALUop = 3'(funct_q);
          CL_ALU_IMM: begin
            ALUop    = 3'(funct_q);
            ALUinSel = ALUIN_IMM;
          end
          CL_LD, CL_ST: begin
            ALUop    = ALUOP_ADD;
            ALUinSel = ALUIN_IMM;
          end
          CL_BR:  conditional   = 3'(funct_q);
          CL_JMP: unconditional = 1'b1;
          CL_JAL: begin
            unconditional = 1'b1;
            RegWrite      = 1'b1;
            DataPCSel     = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        AdSel    = 1'b1;
        MemRead  = (cls_q == CL_LD);
        MemWrite = (cls_q == CL_ST);
      end
      ST_WB: begin
        RegWrite  = 1'b1;
        MemtoReg  = (cls_q == CL_LD);
        RegSelect = (cls_q == CL_ALU_RR);
      end
      ST_HALT: halt    = 1'b1;
      ST_ERR:  bus_err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: table of whole-instruction vectors driven reactively,
// randomized instruction stream against a per-instruction trace model, and corner cases.
module tb_multicycle_control_unit;

  localparam int OPCODE_W    = 6;
  localparam int FUNCT_W     = 3;
  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNCT_W-1:0]  funct;
  logic                mem_ready;
  logic mem_req, AdSel, MemRead, MemWrite, ir_write, pc_write, unconditional;
  logic [2:0] conditional, ALUop;
  logic [1:0] ALUinSel;
  logic RegWrite, RegSelect, MemtoReg, DataPCSel, halt, bus_err, illegal;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(OPCODE_W), .FUNCT_W(FUNCT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdSel(AdSel), .MemRead(MemRead), .MemWrite(MemWrite),
    .ir_write(ir_write), .pc_write(pc_write), .unconditional(unconditional),
    .conditional(conditional), .ALUop(ALUop), .ALUinSel(ALUinSel),
    .RegWrite(RegWrite), .RegSelect(RegSelect), .MemtoReg(MemtoReg),
    .DataPCSel(DataPCSel), .halt(halt), .bus_err(bus_err), .illegal(illegal),
    .retired(retired)
  );

  typedef struct packed {
    logic mem_req, adsel, memread, memwrite, ir_write, pc_write, uncond;
    logic [2:0] cond;
    logic [2:0] aluop;
    logic [1:0] alusel;
    logic regwrite, regselect, memtoreg, datapcsel, halt, bus_err, illegal;
  } outs_t;

  outs_t act;
  assign act = {mem_req, AdSel, MemRead, MemWrite, ir_write, pc_write, unconditional,
                conditional, ALUop, ALUinSel, RegWrite, RegSelect, MemtoReg, DataPCSel,
                halt, bus_err, illegal};

  typedef enum {K_RR, K_IMM, K_LD, K_ST, K_BR, K_JMP, K_JAL, K_HLT, K_ILL} kind_e;
  typedef struct {outs_t o; logic rdy; logic mem; logic dec;} cyc_t;

  typedef struct {
    logic [5:0] op; logic [2:0] f; int fw; int mw; int cycles;
    logic [2:0] aluop; logic [1:0] alusel; logic [2:0] cond;
    logic uncond; logic regwrite; logic memtoreg; logic illegal; int memcyc;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;
  cyc_t trace[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [5:0] op);
    if (op == 6'h3f) return K_HLT;
    case (op)
      6'd0: return K_RR;
      6'd1: return K_IMM;
      6'd2: return K_LD;
      6'd3: return K_ST;
      6'd4: return K_BR;
      6'd5: return K_JMP;
      6'd6: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] exp_retired();
    return 32'(exp_ret % (1 << CNT_W));
  endfunction

  // Expected per-cycle outputs of one instruction; a wait count of -1 means ready never comes.
  task automatic build(input logic [5:0] op, input logic [2:0] f, input int fw, input int mw);
    kind_e k = kind_of(op);
    cyc_t  c;
    int    n;
    trace.delete();
    n = (fw < 0) ? MEM_TIMEOUT + 1 : fw + 1;
    for (int i = 0; i < n; i++) begin
      c = '{o: '0, rdy: 1'b0, mem: 1'b1, dec: 1'b0};
      c.o.mem_req = 1'b1;
      c.o.memread = 1'b1;
      if (i == fw) begin
        c.rdy = 1'b1;
        c.o.ir_write = 1'b1;
        c.o.pc_write = 1'b1;
      end
      trace.push_back(c);
    end
    c = '{o: '0, rdy: 1'b0, mem: 1'b0, dec: 1'b0};
    if (fw < 0) begin
      c.o.bus_err = 1'b1;
      trace.push_back(c);
      return;
    end
    c.dec = 1'b1;
    c.o.illegal = (k == K_ILL);
    trace.push_back(c);
    c = '{o: '0, rdy: 1'b0, mem: 1'b0, dec: 1'b0};
    if (k == K_HLT) begin
      c.o.halt = 1'b1;
      trace.push_back(c);
      return;
    end
    if (k == K_ILL) return;
    case (k)
      K_RR:  c.o.aluop = f;
      K_IMM: begin c.o.aluop = f; c.o.alusel = 2'b01; end
      K_LD, K_ST: c.o.alusel = 2'b01;
      K_BR:  c.o.cond = f;
      K_JMP: c.o.uncond = 1'b1;
      K_JAL: begin c.o.uncond = 1'b1; c.o.regwrite = 1'b1; c.o.datapcsel = 1'b1; end
      default: ;
    endcase
    trace.push_back(c);
    if (k == K_LD || k == K_ST) begin
      n = (mw < 0) ? MEM_TIMEOUT + 1 : mw + 1;
      for (int i = 0; i < n; i++) begin
        c = '{o: '0, rdy: (i == mw), mem: 1'b1, dec: 1'b0};
        c.o.mem_req  = 1'b1;
        c.o.adsel    = 1'b1;
        c.o.memread  = (k == K_LD);
        c.o.memwrite = (k == K_ST);
        trace.push_back(c);
      end
      if (mw < 0) begin
        c = '{o: '0, rdy: 1'b0, mem: 1'b0, dec: 1'b0};
        c.o.bus_err = 1'b1;
        trace.push_back(c);
        return;
      end
    end
    if (k == K_RR || k == K_IMM || k == K_LD) begin
      c = '{o: '0, rdy: 1'b0, mem: 1'b0, dec: 1'b0};
      c.o.regwrite  = 1'b1;
      c.o.memtoreg  = (k == K_LD);
      c.o.regselect = (k == K_RR);
      trace.push_back(c);
    end
  endtask

  // Irrelevant inputs are randomized so the DUT is seen to ignore them.
  task automatic play(input logic [5:0] op, input logic [2:0] f, input int limit);
    for (int i = 0; i < trace.size() && i < limit; i++) begin
      opcode    = trace[i].dec ? op : 6'($urandom);
      funct     = trace[i].dec ? f : 3'($urandom);
      mem_ready = trace[i].mem ? trace[i].rdy : 1'($urandom);
      #4;
      check($sformatf("outs op%0h cyc%0d", op, i), 32'(act), 32'(trace[i].o));
      check($sformatf("retired op%0h cyc%0d", op, i), 32'(retired), exp_retired());
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [2:0] f, input int fw, input int mw);
    kind_e k = kind_of(op);
    build(op, f, fw, mw);
    play(op, f, trace.size());
    if (k != K_HLT && fw >= 0 && !(mw < 0 && (k == K_LD || k == K_ST))) exp_ret++;
  endtask

  task automatic hold(input string name, input outs_t e, input int n);
    for (int i = 0; i < n; i++) begin
      opcode    = 6'($urandom);
      funct     = 3'($urandom);
      mem_ready = 1'($urandom);
      #4;
      check($sformatf("%s hold%0d", name, i), 32'(act), 32'(e));
      @(posedge clk); #1;
    end
  endtask

  // Leaves the bench one cycle into FETCH, with the RST cycle checked on the way.
  task automatic do_reset();
    reset     = 1'b1;
    mem_ready = 1'($urandom);
    exp_ret   = 0;
    @(posedge clk); #1;
    check("reset outs", 32'(act), 32'(0));
    check("reset retired", 32'(retired), 32'(0));
    reset = 1'b0;
    #4;
    check("rst-state outs", 32'(act), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, fcnt = 0, mcnt = 0, memcyc = 0;
    bit left = 1'b0, done = 1'b0;
    logic [2:0] aluop_or = '0, cond_or = '0;
    logic [1:0] alusel_or = '0;
    logic unc_or = 1'b0, rw_or = 1'b0, m2r_or = 1'b0, ill_or = 1'b0;
    while (!done && cyc < 64) begin
      if (mem_req && !AdSel && left) begin
        done = 1'b1;
      end else begin
        opcode = v.op;
        funct  = v.f;
        if (mem_req && !AdSel) begin
          mem_ready = (fcnt == v.fw);
          fcnt++;
        end else if (mem_req && AdSel) begin
          left = 1'b1;
          mem_ready = (mcnt == v.mw);
          mcnt++;
        end else begin
          left = 1'b1;
          mem_ready = 1'($urandom);
        end
        #4;
        aluop_or  |= ALUop;
        alusel_or |= ALUinSel;
        cond_or   |= conditional;
        unc_or    |= unconditional;
        rw_or     |= RegWrite;
        m2r_or    |= MemtoReg;
        ill_or    |= illegal;
        if (mem_req && AdSel && (MemRead || MemWrite)) memcyc++;
        cyc++;
        @(posedge clk); #1;
      end
    end
    exp_ret++;
    check($sformatf("vec%0d cycles", idx), 32'(cyc), 32'(v.cycles));
    check($sformatf("vec%0d ALUop", idx), 32'(aluop_or), 32'(v.aluop));
    check($sformatf("vec%0d ALUinSel", idx), 32'(alusel_or), 32'(v.alusel));
    check($sformatf("vec%0d conditional", idx), 32'(cond_or), 32'(v.cond));
    check($sformatf("vec%0d unconditional", idx), 32'(unc_or), 32'(v.uncond));
    check($sformatf("vec%0d RegWrite", idx), 32'(rw_or), 32'(v.regwrite));
    check($sformatf("vec%0d MemtoReg", idx), 32'(m2r_or), 32'(v.memtoreg));
    check($sformatf("vec%0d illegal", idx), 32'(ill_or), 32'(v.illegal));
    check($sformatf("vec%0d mem cycles", idx), 32'(memcyc), 32'(v.memcyc));
    check($sformatf("vec%0d retired", idx), 32'(retired), exp_retired());
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : MEM_TIMEOUT;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[9];
    outs_t e;
    int    r;
    logic [5:0] op;

    //         op     f     fw  mw  cyc  aluop  alusel cond  unc   rw    m2r   ill  memcyc
    vecs[0] = '{6'h01, 3'd2, 0,  0,  4,  3'd2, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{6'h02, 3'd5, 0,  3,  8,  3'd0, 2'b01, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4};
    vecs[2] = '{6'h00, 3'd6, 2,  0,  6,  3'd6, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{6'h03, 3'd1, 1,  2,  7,  3'd0, 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    vecs[4] = '{6'h04, 3'd3, 0,  0,  3,  3'd0, 2'b00, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[5] = '{6'h05, 3'd7, 0,  0,  3,  3'd0, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[6] = '{6'h06, 3'd0, 1,  0,  4,  3'd0, 2'b00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[7] = '{6'h2a, 3'd4, 0,  0,  2,  3'd0, 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vecs[8] = '{6'h01, 3'd7, 15, 0,  19, 3'd7, 2'b01, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0};

    reset = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0;
    do_reset();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    for (int i = 0; i < 40; i++) begin
      r  = int'($urandom_range(0, 7));
      op = (r < 7) ? 6'(r) : 6'($urandom_range(7, 62));
      run_instr(op, 3'($urandom), pick_wait(), pick_wait());
    end

    // Illegal opcode followed immediately by a normal fetch.
    run_instr(6'h2a, 3'd1, 0, 0);
    run_instr(6'h01, 3'd2, 0, 0);

    // HLT: halt from the third cycle, held until reset.
    run_instr(6'h3f, 3'd0, 0, 0);
    e = '0; e.halt = 1'b1;
    hold("halt", e, 5);
    check("halt retired", 32'(retired), exp_retired());
    do_reset();

    // Fetch timeout, then data-phase timeout.
    run_instr(6'h01, 3'd0, -1, 0);
    e = '0; e.bus_err = 1'b1;
    hold("fetch timeout", e, 4);
    do_reset();
    run_instr(6'h03, 3'd2, 0, -1);
    hold("mem timeout", e, 4);
    do_reset();

    // Reset in the middle of a load's data wait abandons the access.
    run_instr(6'h00, 3'd3, 0, 0);
    build(6'h02, 3'd0, 0, -1);
    play(6'h02, 3'd0, 6);
    do_reset();
    run_instr(6'h05, 3'd0, 1, 0);
    run_instr(6'h02, 3'd0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
